// File: rtl/fifo_wr_packer.sv
// Write-domain packer: gathers RATIO narrow beats into one wide FIFO entry and
// issues it through a one-entry output register. Option: FIFO_WR_PACKER_LAST_FLUSH_EN.
module fifo_wr_packer #(
    parameter int IN_BITS = 8,
    parameter int RATIO   = 4
) (
    input  logic                       write_clk,
    input  logic                       write_rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_BITS-1:0]         s_data,
    input  logic                       s_last,
    output logic                       m_write_en,
    output logic [IN_BITS*RATIO-1:0]   m_write_data,
    input  logic                       m_write_full,
    output logic [15:0]                o_word_count
);

    localparam int OUT_BITS = IN_BITS * RATIO;
    localparam int CNT_BITS = $clog2(RATIO);
    localparam logic [CNT_BITS-1:0] LAST_LANE = CNT_BITS'(RATIO - 1);

    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $fatal(1, "fifo_wr_packer: RATIO must be a power of two >= 2");
    end

    logic [CNT_BITS-1:0] cnt;
    logic [OUT_BITS-1:0] acc;
    logic [OUT_BITS-1:0] next_word;
    logic [OUT_BITS-1:0] out_data;
    logic                out_valid;
    logic [15:0]         word_count;
    logic                accept;
    logic                complete;

    assign m_write_en   = out_valid && !m_write_full;
    assign m_write_data = out_data;
    assign s_ready      = !out_valid || m_write_en;
    assign accept       = s_valid && s_ready;
    assign o_word_count = word_count;

`ifdef FIFO_WR_PACKER_LAST_FLUSH_EN
    assign complete = accept && (s_last || cnt == LAST_LANE);
`else
    logic s_last_unused;
    assign s_last_unused = s_last;
    assign complete = accept && (cnt == LAST_LANE);
`endif

    // Accumulator with the current beat merged into lane cnt.
    always_comb begin
        next_word = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (CNT_BITS'(k) == cnt) begin
                next_word[k*IN_BITS +: IN_BITS] = s_data;
            end
`ifdef FIFO_WR_PACKER_LAST_FLUSH_EN
            else if (s_last && CNT_BITS'(k) > cnt) begin
                next_word[k*IN_BITS +: IN_BITS] = '0;
            end
`endif
        end
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            cnt        <= '0;
            acc        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            word_count <= '0;
        end else begin
            if (accept) begin
                acc <= next_word;
                cnt <= complete ? '0 : cnt + 1'b1;
            end
            // A completing beat on a draining edge replaces the word in place.
            if (complete) begin
                out_data  <= next_word;
                out_valid <= 1'b1;
            end else if (m_write_en) begin
                out_valid <= 1'b0;
            end
            if (m_write_en) begin
                word_count <= word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer (IN_BITS=8, RATIO=4); writes are logged at the
// falling edge of every cycle in which m_write_en is high.
module tb_fifo_wr_packer;

    logic        write_clk;
    logic        write_rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_write_en;
    logic [31:0] m_write_data;
    logic        m_write_full;
    logic [15:0] o_word_count;

    int passes = 0;
    int checks = 0;
    logic [31:0] wlog[$];

    fifo_wr_packer #(.IN_BITS(8), .RATIO(4)) dut (
        .write_clk    (write_clk),
        .write_rst_n  (write_rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .m_write_en   (m_write_en),
        .m_write_data (m_write_data),
        .m_write_full (m_write_full),
        .o_word_count (o_word_count)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    always @(negedge write_clk) begin
        if (write_rst_n === 1'b1 && m_write_en === 1'b1) wlog.push_back(m_write_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        write_rst_n  = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        s_last       = 1'b0;
        m_write_full = 1'b0;
        tick();
        tick();
        write_rst_n = 1'b1;
        wlog.delete();
    endtask

    task automatic test_reset();
        write_rst_n  = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        s_last       = 1'b0;
        m_write_full = 1'b0;
        @(negedge write_clk);
        checks++; if (m_write_en !== 1'b0) $display("FAIL reset_en: got %b expected 0", m_write_en); else passes++;
        checks++; if (m_write_data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", m_write_data); else passes++;
        checks++; if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", s_ready); else passes++;
        checks++; if (o_word_count !== 16'h0) $display("FAIL reset_count: got %h expected 0000", o_word_count); else passes++;
        tick();
        write_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] b [4];
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = b[i];
            @(negedge write_clk);
            checks++; if (m_write_en !== 1'b0) $display("FAIL basic_en_early beat %0d: got %b expected 0", i, m_write_en); else passes++;
            tick();
        end
        s_valid = 1'b0;
        @(negedge write_clk);
        checks++; if (m_write_en !== 1'b1) $display("FAIL basic_en: got %b expected 1", m_write_en); else passes++;
        checks++; if (m_write_data !== 32'h44332211) $display("FAIL basic_data: got %h expected 44332211", m_write_data); else passes++;
        tick();
        @(negedge write_clk);
        checks++; if (m_write_en !== 1'b0) $display("FAIL basic_en_after: got %b expected 0", m_write_en); else passes++;
        checks++; if (o_word_count !== 16'd1) $display("FAIL basic_count: got %0d expected 1", o_word_count); else passes++;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            @(negedge write_clk);
            checks++; if (s_ready !== 1'b1) $display("FAIL stream_ready beat %0d: got %b expected 1", i, s_ready); else passes++;
            tick();
        end
        s_valid = 1'b0;
        tick();
        tick();
        checks++; if (wlog.size() !== 4) $display("FAIL stream_writes: got %0d expected 4", wlog.size()); else passes++;
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            checks++; if (wlog[k] !== exp) $display("FAIL stream_word %0d: got %h expected %h", k, wlog[k], exp); else passes++;
        end
        checks++; if (o_word_count !== 16'd4) $display("FAIL stream_count: got %0d expected 4", o_word_count); else passes++;
    endtask

    task automatic test_backpressure();
        do_reset();
        m_write_full = 1'b1;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hB1;
        for (int i = 0; i < 5; i++) begin
            @(negedge write_clk);
            checks++; if (m_write_en !== 1'b0) $display("FAIL bp_en cycle %0d: got %b expected 0", i, m_write_en); else passes++;
            checks++; if (m_write_data !== 32'hA4A3A2A1) $display("FAIL bp_data cycle %0d: got %h expected A4A3A2A1", i, m_write_data); else passes++;
            checks++; if (s_ready !== 1'b0) $display("FAIL bp_ready cycle %0d: got %b expected 0", i, s_ready); else passes++;
            tick();
        end
        m_write_full = 1'b0;
        @(negedge write_clk);
        checks++; if (m_write_en !== 1'b1) $display("FAIL bp_release_en: got %b expected 1", m_write_en); else passes++;
        checks++; if (s_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", s_ready); else passes++;
        tick();
        s_valid = 1'b0;
        @(negedge write_clk);
        checks++; if (m_write_en !== 1'b0) $display("FAIL bp_after_en: got %b expected 0", m_write_en); else passes++;
        checks++; if (o_word_count !== 16'd1) $display("FAIL bp_after_count: got %0d expected 1", o_word_count); else passes++;
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        send(8'hB4, 1'b0);
        tick();
        tick();
        checks++; if (wlog.size() !== 2) $display("FAIL bp_writes: got %0d expected 2", wlog.size()); else passes++;
        if (wlog.size() >= 2) begin
            checks++; if (wlog[0] !== 32'hA4A3A2A1) $display("FAIL bp_word0: got %h expected A4A3A2A1", wlog[0]); else passes++;
            checks++; if (wlog[1] !== 32'hB4B3B2B1) $display("FAIL bp_word1: got %h expected B4B3B2B1", wlog[1]); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h10, 1'b0);
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b0);
        tick();
        m_write_full = 1'b1;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        write_rst_n  = 1'b0;
        m_write_full = 1'b0;
        @(negedge write_clk);
        checks++; if (m_write_en !== 1'b0) $display("FAIL rstmid_en: got %b expected 0", m_write_en); else passes++;
        checks++; if (m_write_data !== 32'h0) $display("FAIL rstmid_data: got %h expected 00000000", m_write_data); else passes++;
        checks++; if (s_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", s_ready); else passes++;
        checks++; if (o_word_count !== 16'h0) $display("FAIL rstmid_count: got %h expected 0000", o_word_count); else passes++;
        tick();
        write_rst_n = 1'b1;
        wlog.delete();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        write_rst_n = 1'b0;
        tick();
        write_rst_n = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        tick();
        tick();
        tick();
        checks++; if (wlog.size() !== 1) $display("FAIL rstmid_writes: got %0d expected 1", wlog.size()); else passes++;
        if (wlog.size() >= 1) begin
            checks++; if (wlog[0] !== 32'h04030201) $display("FAIL rstmid_word: got %h expected 04030201", wlog[0]); else passes++;
        end
        checks++; if (o_word_count !== 16'd1) $display("FAIL rstmid_final_count: got %0d expected 1", o_word_count); else passes++;
    endtask

    task automatic test_last();
        do_reset();
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        tick();
        tick();
`ifdef FIFO_WR_PACKER_LAST_FLUSH_EN
        checks++; if (wlog.size() !== 1) $display("FAIL last_writes: got %0d expected 1", wlog.size()); else passes++;
        if (wlog.size() >= 1) begin
            checks++; if (wlog[0] !== 32'h00002211) $display("FAIL last_word: got %h expected 00002211", wlog[0]); else passes++;
        end
        for (int i = 1; i <= 3; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            s_last  = 1'b1;
            @(negedge write_clk);
            checks++; if (s_ready !== 1'b1) $display("FAIL last_b2b_ready beat %0d: got %b expected 1", i, s_ready); else passes++;
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        tick();
        checks++; if (wlog.size() !== 4) $display("FAIL last_b2b_writes: got %0d expected 4", wlog.size()); else passes++;
        for (int k = 1; k < 4 && k < wlog.size(); k++) begin
            checks++; if (wlog[k] !== 32'(k)) $display("FAIL last_b2b_word %0d: got %h expected %h", k, wlog[k], 32'(k)); else passes++;
        end
        checks++; if (o_word_count !== 16'd4) $display("FAIL last_b2b_count: got %0d expected 4", o_word_count); else passes++;
`else
        checks++; if (wlog.size() !== 0) $display("FAIL last_ignored: got %0d writes expected 0", wlog.size()); else passes++;
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        tick();
        tick();
        checks++; if (wlog.size() !== 1) $display("FAIL last_writes: got %0d expected 1", wlog.size()); else passes++;
        if (wlog.size() >= 1) begin
            checks++; if (wlog[0] !== 32'h44332211) $display("FAIL last_word: got %h expected 44332211", wlog[0]); else passes++;
        end
`endif
    endtask

    task automatic test_wrap();
        logic [15:0] exp;
        do_reset();
        force dut.word_count = 16'hFFFE;
        tick();
        release dut.word_count;
        @(negedge write_clk);
        checks++; if (o_word_count !== 16'hFFFE) $display("FAIL wrap_preload: got %h expected FFFE", o_word_count); else passes++;
        exp = 16'hFFFE;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 4; i++) send(8'(16*w + i), 1'b0);
            tick();
            exp = exp + 16'd1;
            checks++; if (o_word_count !== exp) $display("FAIL wrap_count word %0d: got %h expected %h", w, o_word_count, exp); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_last();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_packer.md
# fifo_wr_packer

Write-domain front end for the dual-clock FIFO. It accepts narrow beats from a valid/ready source and packs RATIO consecutive beats into one wide FIFO entry. It holds each completed word in a one-entry output register and issues it to the FIFO write port without ever writing while the FIFO reports full. It sits directly upstream of the async FIFO, in the write_clk domain, and its output ports connect one-to-one to the FIFO write port.

## Interface
- IN_BITS, 8, width of one input beat.
- RATIO, 4, beats per FIFO entry; must be a power of two ≥ 2, otherwise elaboration fails with $fatal.
- OUT_BITS (localparam), IN_BITS*RATIO, FIFO entry width; must equal the FIFO BITS parameter.
- write_clk  input  1  write-domain clock.
- write_rst_n  input  1  reset write_rst_n, asynchronous, active-low; clock write_clk.
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  upstream beat ready.
- s_data  input  IN_BITS  upstream beat data.
- s_last  input  1  end-of-packet marker; used only with the macro enabled.
- m_write_en  output  1  to FIFO p_write_en.
- m_write_data  output  OUT_BITS  to FIFO p_write_data.
- m_write_full  input  1  from FIFO p_write_full.
- o_word_count  output  16  count of words written to the FIFO, wraps.

## Operation
- Beat accepted when s_valid && s_ready at the rising edge of write_clk.
- Lane counter cnt, $clog2(RATIO) bits, starts at 0. An accepted beat writes s_data into lane cnt of the accumulator, so lane k occupies bits [k*IN_BITS +: IN_BITS]. The first beat lands in the LSBs.
- Completing beat: an accepted beat with cnt == RATIO-1. On that edge the full word (accumulator plus the current beat) loads into out_data, out_valid is set, and cnt returns to 0.
- Otherwise cnt increments by 1; no other wrap behaviour exists.
- m_write_en = out_valid && !m_write_full, combinational. m_write_data = out_data.
- Word drains at an edge where m_write_en = 1: out_valid clears unless a completing beat reloads it on the same edge.
- s_ready = !out_valid || m_write_en, combinational. It never depends on s_valid, s_data or s_last.
- While out_valid && m_write_full: m_write_en = 0, out_data held stable, s_ready = 0.
- The accumulator and cnt are never lost by backpressure. Non-completing beats are still accepted only while s_ready = 1.
- o_word_count increments by 1 on every edge where m_write_en = 1; 0xFFFF wraps to 0x0000.
- Unused accumulator lanes have no defined value except where the macro requires zero padding.

## Timing
- Reset (asynchronous assert, synchronous-to-write_clk deassert by the system) sets:
  - cnt = 0, accumulator = 0, out_valid = 0, out_data = 0, o_word_count = 0.
  - As a result m_write_en = 0, m_write_data = 0, s_ready = 1.
- Reset mid-word discards the partial word. Reset with out_valid = 1 discards the pending word; nothing is written.
- Latency: a completing beat accepted at edge N gives m_write_en = 1 during cycle N+1 if m_write_full = 0. The FIFO captures the word at edge N+1.
- Throughput: one beat per cycle sustained while m_write_full stays 0; s_ready stays constantly 1.
- Simultaneous drain and completing beat on one edge: the new word replaces the old one, out_valid stays 1, and the count increments once.
- m_write_full rising while m_write_en would be asserted: the write is suppressed in that cycle, with no glitch-write.

## Configuration
- FIFO_WR_PACKER_LAST_FLUSH_EN defined:
  - A beat accepted with s_last = 1 is also a completing beat at any cnt.
  - Lanes above cnt are zero-filled in out_data, and cnt returns to 0.
  - s_last on a beat with cnt == RATIO-1 behaves exactly like a normal completion.
- Macro undefined:
  - s_last is ignored (port still present, unconnected internally).
  - Words complete only after RATIO beats, and a partial word waits indefinitely for more beats.

## Test plan
- IN_BITS=8, RATIO=4; beats 0x11, 0x22, 0x33, 0x44 back-to-back, full=0 -> m_write_data=0x44332211 and m_write_en high exactly one cycle, the cycle after the 0x44 beat; o_word_count=1.
- 16 consecutive beats 0x00..0x0F, full=0 -> s_ready constantly 1; four writes 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; o_word_count=4.
- Word pending with m_write_full high for 5 cycles -> m_write_en=0 and data stable throughout, s_ready=0. On the first cycle full=0, m_write_en=1 and s_ready=1.
- write_rst_n pulsed after beats 0xAA, 0xBB -> all outputs at reset values. The next beats 0x01..0x04 produce exactly one write of 0x04030201.
- s_last with the 2nd beat (0x11, 0x22) -> macro on: write 0x00002211. Macro off: no write until two more beats (0x33, 0x44) arrive, then 0x44332211.
- Preload o_word_count near wrap via 65537 writes -> count reads 0x0001 after the last write.
